sram_stream_reader: RTL

//  Read-side master for the 32kx32 dual-port activation/weight SRAM read port.

---
 rtl/sram_stream_reader.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sram_stream_reader.sv
// Sequential read master for SRAM port b: turns an (addr, len) command into a
// valid/ready word stream, with a small credit-limited FIFO covering read latency.
module sram_stream_reader #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              sram_enb,
  output logic [ADDR_W-1:0] sram_addrb,
  input  logic [DATA_W-1:0] sram_doutb,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q, issued_q;
  logic              inflight_q, inflight_last_q;
  logic              done_q;
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic accept, rd_en, is_last_rd, push, pop;

  assign cmd_ready  = (state == IDLE);
  assign accept     = cmd_valid & cmd_ready;
  assign is_last_rd = (issued_q == len_q - LEN_W'(1));
  assign push       = inflight_q;
  assign m_valid    = (count != '0);
  assign pop        = m_valid & m_ready;
  // Gated so the idle/reset stream outputs read as zero rather than stale RAM.
  assign m_data     = m_valid ? fifo_data[rd_ptr] : '0;
  assign m_last     = m_valid ? fifo_last[rd_ptr] : 1'b0;
  assign sram_enb   = rd_en;
  assign sram_addrb = addr_q;
  assign busy       = (state != IDLE);
  assign done       = done_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    case (state)
      IDLE: begin
        if (accept && cmd_len != '0) state_nx = READ;
      end
      READ: begin
        // Credit: words buffered plus the one still in the RAM pipeline.
        rd_en = (issued_q < len_q) &&
                ((count + CNT_W'(inflight_q)) < CNT_W'(FIFO_DEPTH));
        if (rd_en && is_last_rd) state_nx = DRAIN;
      end
      DRAIN: begin
        if (pop && m_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      fifo_last       <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
    end else begin
      inflight_q      <= rd_en;
      inflight_last_q <= rd_en & is_last_rd;
      done_q          <= (accept && cmd_len == '0) ||
                         (state == DRAIN && pop && m_last);
      if (accept) begin
        addr_q   <= cmd_addr;
        len_q    <= cmd_len;
        issued_q <= '0;
      end else if (rd_en) begin
        addr_q   <= addr_q + ADDR_W'(1);
        issued_q <= issued_q + LEN_W'(1);
      end
      if (push) begin
        fifo_last[wr_ptr] <= inflight_last_q;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr] <= sram_doutb;
  end

endmodule
